// File: rtl/store_checker_pkg.sv
// store_checker_pkg
// Shared definitions for the store-stream checker: the checker state
// enumeration, the cause codes reported on a failure, and the width of the
// saturating retry counter.
package store_checker_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_PASS  = 2'd2,
        ST_FAIL  = 2'd3
    } state_t;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ADDR    = 2'd1;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'd2;

    localparam int RETRY_W = 16;

endpackage

// File: rtl/store_checker_if.sv
// store_checker_if
// Bundles the buses the checker observes: the core's data-memory write port
// (memwrite, dataaddr, writedata) and the expected-table write port
// (tbl_we, tbl_idx, tbl_addr, tbl_data).
//   master : the side that drives the buses (core / bench / loader)
//   slave  : the checker, which only observes them
// Parameters ADDR_W, DATA_W and DEPTH must match the checker instance.
interface store_checker_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic              memwrite;
    logic [ADDR_W-1:0] dataaddr;
    logic [DATA_W-1:0] writedata;

    logic              tbl_we;
    logic [IDX_W-1:0]  tbl_idx;
    logic [ADDR_W-1:0] tbl_addr;
    logic [DATA_W-1:0] tbl_data;

    modport master (
        output memwrite, dataaddr, writedata,
        output tbl_we, tbl_idx, tbl_addr, tbl_data
    );

    modport slave (
        input memwrite, dataaddr, writedata,
        input tbl_we, tbl_idx, tbl_addr, tbl_data
    );
endinterface

// File: rtl/store_checker_table.sv
// store_checker_table
// DEPTH-entry register file holding the expected (address, data) pairs.
// One synchronous write port and one combinational read port.
//   clk      in   write clock, rising edge
//   we       in   write enable (already gated by the checker state)
//   wr_idx   in   entry to write
//   wr_addr  in   expected address to store
//   wr_data  in   expected data to store
//   rd_idx   in   entry to read
//   rd_addr  out  expected address of entry rd_idx
//   rd_data  out  expected data of entry rd_idx
// The table has no reset: its contents survive a checker reset.
module store_checker_table #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8,
    parameter int IDX_W  = 3
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  wr_idx,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [IDX_W-1:0]  rd_idx,
    output logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [ADDR_W-1:0] addr_mem [DEPTH];
    logic [DATA_W-1:0] data_mem [DEPTH];

    // When DEPTH is not a power of two the index can name a missing entry;
    // such writes are dropped and such reads return zero.
    if ((2 ** IDX_W) == DEPTH) begin : g_full
        always_ff @(posedge clk) begin
            if (we) begin
                addr_mem[wr_idx] <= wr_addr;
                data_mem[wr_idx] <= wr_data;
            end
        end

        assign rd_addr = addr_mem[rd_idx];
        assign rd_data = data_mem[rd_idx];
    end else begin : g_partial
        always_ff @(posedge clk) begin
            if (we && (int'(wr_idx) < DEPTH)) begin
                addr_mem[wr_idx] <= wr_addr;
                data_mem[wr_idx] <= wr_data;
            end
        end

        always_comb begin
            rd_addr = '0;
            rd_data = '0;
            if (int'(rd_idx) < DEPTH) begin
                rd_addr = addr_mem[rd_idx];
                rd_data = data_mem[rd_idx];
            end
        end
    end

endmodule

// File: rtl/store_checker.sv
// store_checker
// Watches the core's data-memory write port and checks the store stream
// against an in-order table of up to DEPTH expected (address, data) pairs.
// Reports a sticky pass/fail with a cause code, match and retry counters,
// and a watchdog that fails the run when no match arrives for TIMEOUT
// armed cycles.
//
// Ports:
//   clk        in   core clock, rising edge
//   reset      in   asynchronous, active-high
//   bus        slave of store_checker_if: memwrite/dataaddr/writedata store
//              port and tbl_we/tbl_idx/tbl_addr/tbl_data table write port
//   num_exp    in   entries to check, sampled on start (clamped to DEPTH)
//   start      in   arm the checker (from any state)
//   busy       out  checker is ARMED
//   pass       out  sticky pass
//   fail       out  sticky fail
//   cause      out  0 none, 1 wrong address, 2 timeout
//   match_cnt  out  stores matched so far
//   retry_cnt  out  right-address / wrong-data stores, saturating
//   fail_addr  out  offending store address (logging build only, else 0)
//   fail_data  out  offending store data    (logging build only, else 0)
//
// Build option: define STORE_CHECKER_LOG_EN to capture the offending store
// (or, on timeout, the awaited table entry) into fail_addr/fail_data.
module store_checker
    import store_checker_pkg::*;
#(
    parameter  int ADDR_W       = 32,
    parameter  int DATA_W       = 32,
    parameter  int DEPTH        = 8,
    parameter  int TIMEOUT      = 256,
    parameter  int IGNORE_OTHER = 0,
    localparam int IDX_W        = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W        = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    store_checker_if.slave     bus,
    input  logic [CNT_W-1:0]   num_exp,
    input  logic               start,
    output logic               busy,
    output logic               pass,
    output logic               fail,
    output logic [1:0]         cause,
    output logic [CNT_W-1:0]   match_cnt,
    output logic [RETRY_W-1:0] retry_cnt,
    output logic [ADDR_W-1:0]  fail_addr,
    output logic [DATA_W-1:0]  fail_data
);

    localparam int WD_W = $clog2(TIMEOUT);

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q;
    logic [CNT_W-1:0]  num_exp_q;
    logic [CNT_W-1:0]  match_cnt_q;
    logic [RETRY_W-1:0] retry_cnt_q;
    logic [WD_W-1:0]   wd_q;
    logic [1:0]        cause_q;

    logic [ADDR_W-1:0] exp_addr;
    logic [DATA_W-1:0] exp_data;
    logic [CNT_W-1:0]  num_exp_clamped;
    logic              armed;
    logic              store_seen;
    logic              addr_hit;
    logic              data_hit;
    logic              store_ok;
    logic              store_retry;
    logic              store_bad;
    logic              last_match;
    logic              wd_expire;

    // The table only accepts writes while no comparison is in progress, so
    // the entries being checked cannot change under an armed run.
    store_checker_table #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_table (
        .clk     (clk),
        .we      (bus.tbl_we && (state_q != ST_ARMED)),
        .wr_idx  (bus.tbl_idx),
        .wr_addr (bus.tbl_addr),
        .wr_data (bus.tbl_data),
        .rd_idx  (idx_q),
        .rd_addr (exp_addr),
        .rd_data (exp_data)
    );

    assign num_exp_clamped = (num_exp > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : num_exp;

    // A store is only judged while armed and not being re-armed in the same
    // cycle: start always takes priority over a concurrent store.
    assign armed       = (state_q == ST_ARMED) && !start;
    assign store_seen  = armed && bus.memwrite;
    assign addr_hit    = (bus.dataaddr == exp_addr);
    assign data_hit    = (bus.writedata == exp_data);
    assign store_ok    = store_seen && addr_hit && data_hit;
    assign store_retry = store_seen && addr_hit && !data_hit;
    assign store_bad   = store_seen && !addr_hit && (IGNORE_OTHER == 0);
    assign last_match  = store_ok && ((match_cnt_q + CNT_W'(1)) == num_exp_q);

    // The watchdog holds the number of armed cycles already spent waiting;
    // the cycle that would bring it to TIMEOUT fails the run instead, unless
    // that same cycle brings a match or an address failure.
    assign wd_expire = armed && !store_ok && !store_bad &&
                       (wd_q == WD_W'(TIMEOUT - 1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = (num_exp_clamped == '0) ? ST_PASS : ST_ARMED;
        end else if (state_q == ST_ARMED) begin
            if (last_match) begin
                state_d = ST_PASS;
            end else if (store_bad || wd_expire) begin
                state_d = ST_FAIL;
            end
        end
    end

    always_comb begin
        busy = (state_q == ST_ARMED);
        pass = (state_q == ST_PASS);
        fail = (state_q == ST_FAIL);
    end

    // Run bookkeeping: pointer, counters, watchdog and cause. The pointer is
    // not advanced on the final match so it never leaves the table range.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idx_q       <= '0;
            num_exp_q   <= '0;
            match_cnt_q <= '0;
            retry_cnt_q <= '0;
            wd_q        <= '0;
            cause_q     <= CAUSE_NONE;
        end else if (start) begin
            idx_q       <= '0;
            num_exp_q   <= num_exp_clamped;
            match_cnt_q <= '0;
            retry_cnt_q <= '0;
            wd_q        <= '0;
            cause_q     <= CAUSE_NONE;
        end else if (state_q == ST_ARMED) begin
            if (store_ok) begin
                match_cnt_q <= match_cnt_q + CNT_W'(1);
                wd_q        <= '0;
                if (!last_match) begin
                    idx_q <= idx_q + IDX_W'(1);
                end
            end else begin
                wd_q <= wd_q + WD_W'(1);
            end

            if (store_retry && (retry_cnt_q != '1)) begin
                retry_cnt_q <= retry_cnt_q + RETRY_W'(1);
            end

            if (store_bad) begin
                cause_q <= CAUSE_ADDR;
            end else if (wd_expire) begin
                cause_q <= CAUSE_TIMEOUT;
            end
        end
    end

    assign cause     = cause_q;
    assign match_cnt = match_cnt_q;
    assign retry_cnt = retry_cnt_q;

`ifdef STORE_CHECKER_LOG_EN
    logic [ADDR_W-1:0] fail_addr_q;
    logic [DATA_W-1:0] fail_data_q;

    // Capture what caused the failure: the stray store itself, or on a
    // timeout the table entry that never arrived.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (start) begin
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else if (store_bad) begin
            fail_addr_q <= bus.dataaddr;
            fail_data_q <= bus.writedata;
        end else if (wd_expire) begin
            fail_addr_q <= exp_addr;
            fail_data_q <= exp_data;
        end
    end

    assign fail_addr = fail_addr_q;
    assign fail_data = fail_data_q;
`else
    assign fail_addr = '0;
    assign fail_data = '0;
`endif

endmodule

// File: tb/tb_store_checker.sv
// tb_store_checker
// Drives two store_checker instances from one shared bus: instance 0 fails on
// stray stores (IGNORE_OTHER=0), instance 1 ignores them (IGNORE_OTHER=1).
// Both run DEPTH=4, TIMEOUT=16. A behavioural model tracks each checker in
// terms of "entries consumed" and "cycle of last progress" and predicts every
// output after every clock. Directed scenarios come first, then a long
// randomized run with occasional asynchronous resets.
module tb_store_checker;

    localparam int AW      = 16;
    localparam int DW      = 16;
    localparam int DEPTH   = 4;
    localparam int TIMEOUT = 16;
    localparam int CW      = $clog2(DEPTH + 1);
    localparam int IW      = $clog2(DEPTH);

    localparam int M_IDLE  = 0;
    localparam int M_ARMED = 1;
    localparam int M_PASS  = 2;
    localparam int M_FAIL  = 3;

    logic clk = 1'b0;
    logic reset;
    logic [CW-1:0] num_exp;
    logic start;

    logic          busy_o  [2];
    logic          pass_o  [2];
    logic          fail_o  [2];
    logic [1:0]    cause_o [2];
    logic [CW-1:0] match_o [2];
    logic [15:0]   retry_o [2];
    logic [AW-1:0] faddr_o [2];
    logic [DW-1:0] fdata_o [2];

    int checks   = 0;
    int failures = 0;

    // Behavioural model state, one slot per instance.
    int            m_mode    [2];
    int            m_nexp    [2];
    int            m_matched [2];
    int            m_retries [2];
    int            m_cause   [2];
    int            m_last    [2];
    logic [AW-1:0] m_fa      [2];
    logic [DW-1:0] m_fd      [2];
    logic [AW-1:0] m_taddr   [2][DEPTH];
    logic [DW-1:0] m_tdata   [2][DEPTH];
    int            cyc = 0;

    always #5 clk = ~clk;

    store_checker_if #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH)) bus ();

    store_checker #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGNORE_OTHER(0)
    ) dut0 (
        .clk(clk), .reset(reset), .bus(bus), .num_exp(num_exp), .start(start),
        .busy(busy_o[0]), .pass(pass_o[0]), .fail(fail_o[0]), .cause(cause_o[0]),
        .match_cnt(match_o[0]), .retry_cnt(retry_o[0]),
        .fail_addr(faddr_o[0]), .fail_data(fdata_o[0])
    );

    store_checker #(
        .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT), .IGNORE_OTHER(1)
    ) dut1 (
        .clk(clk), .reset(reset), .bus(bus), .num_exp(num_exp), .start(start),
        .busy(busy_o[1]), .pass(pass_o[1]), .fail(fail_o[1]), .cause(cause_o[1]),
        .match_cnt(match_o[1]), .retry_cnt(retry_o[1]),
        .fail_addr(faddr_o[1]), .fail_data(fdata_o[1])
    );

    task automatic checkOutput(input string tag, input logic [31:0] actual,
                               input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got %0h expected %0h (t=%0t)", tag, actual, expected, $time);
        end
    endtask

    task automatic modelReset();
        for (int k = 0; k < 2; k++) begin
            m_mode[k]    = M_IDLE;
            m_nexp[k]    = 0;
            m_matched[k] = 0;
            m_retries[k] = 0;
            m_cause[k]   = 0;
            m_last[k]    = 0;
            m_fa[k]      = '0;
            m_fd[k]      = '0;
        end
    endtask

    // Advance the model over the coming rising edge using the inputs now
    // being driven.
    task automatic modelStep();
        bit progressed;
        logic [AW-1:0] ea;
        logic [DW-1:0] ed;
        if (reset) begin
            modelReset();
        end else begin
            for (int k = 0; k < 2; k++) begin
                if (bus.tbl_we && m_mode[k] != M_ARMED) begin
                    m_taddr[k][bus.tbl_idx] = bus.tbl_addr;
                    m_tdata[k][bus.tbl_idx] = bus.tbl_data;
                end
                if (start) begin
                    m_nexp[k]    = (int'(num_exp) > DEPTH) ? DEPTH : int'(num_exp);
                    m_matched[k] = 0;
                    m_retries[k] = 0;
                    m_cause[k]   = 0;
                    m_fa[k]      = '0;
                    m_fd[k]      = '0;
                    m_last[k]    = cyc;
                    m_mode[k]    = (m_nexp[k] == 0) ? M_PASS : M_ARMED;
                end else if (m_mode[k] == M_ARMED) begin
                    progressed = 0;
                    ea = m_taddr[k][m_matched[k]];
                    ed = m_tdata[k][m_matched[k]];
                    if (bus.memwrite) begin
                        if (bus.dataaddr == ea && bus.writedata == ed) begin
                            m_matched[k]++;
                            m_last[k] = cyc;
                            progressed = 1;
                            if (m_matched[k] == m_nexp[k]) m_mode[k] = M_PASS;
                        end else if (bus.dataaddr == ea) begin
                            if (m_retries[k] < 65535) m_retries[k]++;
                        end else if (k == 0) begin
                            m_mode[k]  = M_FAIL;
                            m_cause[k] = 1;
                            m_fa[k]    = bus.dataaddr;
                            m_fd[k]    = bus.writedata;
                        end
                    end
                    if (m_mode[k] == M_ARMED && !progressed && (cyc - m_last[k]) >= TIMEOUT) begin
                        m_mode[k]  = M_FAIL;
                        m_cause[k] = 2;
                        m_fa[k]    = ea;
                        m_fd[k]    = ed;
                    end
                end
            end
        end
        cyc++;
    endtask

    task automatic checkAll();
        for (int k = 0; k < 2; k++) begin
            checkOutput($sformatf("d%0d_busy", k), 32'(busy_o[k]), 32'(m_mode[k] == M_ARMED));
            checkOutput($sformatf("d%0d_pass", k), 32'(pass_o[k]), 32'(m_mode[k] == M_PASS));
            checkOutput($sformatf("d%0d_fail", k), 32'(fail_o[k]), 32'(m_mode[k] == M_FAIL));
            checkOutput($sformatf("d%0d_cause", k), 32'(cause_o[k]), 32'(m_cause[k]));
            checkOutput($sformatf("d%0d_match_cnt", k), 32'(match_o[k]), 32'(m_matched[k]));
            checkOutput($sformatf("d%0d_retry_cnt", k), 32'(retry_o[k]), 32'(m_retries[k]));
`ifdef STORE_CHECKER_LOG_EN
            checkOutput($sformatf("d%0d_fail_addr", k), 32'(faddr_o[k]), 32'(m_fa[k]));
            checkOutput($sformatf("d%0d_fail_data", k), 32'(fdata_o[k]), 32'(m_fd[k]));
`else
            checkOutput($sformatf("d%0d_fail_addr", k), 32'(faddr_o[k]), 32'd0);
            checkOutput($sformatf("d%0d_fail_data", k), 32'(fdata_o[k]), 32'd0);
`endif
        end
    endtask

    // One clock: model the edge, let the DUTs take it, compare on the
    // falling edge, then drop the single-cycle strobes.
    task automatic applyStimulus();
        modelStep();
        @(posedge clk);
        @(negedge clk);
        checkAll();
        bus.memwrite = 1'b0;
        bus.tbl_we   = 1'b0;
        start        = 1'b0;
    endtask

    task automatic setStore(input int a, input int d);
        bus.memwrite  = 1'b1;
        bus.dataaddr  = AW'(a);
        bus.writedata = DW'(d);
    endtask

    task automatic setWrite(input int i, input int a, input int d);
        bus.tbl_we   = 1'b1;
        bus.tbl_idx  = IW'(i);
        bus.tbl_addr = AW'(a);
        bus.tbl_data = DW'(d);
    endtask

    task automatic setStart(input int n);
        start   = 1'b1;
        num_exp = CW'(n);
    endtask

    // Asynchronous reset: outputs must clear before any clock edge.
    task automatic resetPulse();
        reset = 1'b1;
        #1;
        modelReset();
        checkAll();
        checkOutput("rst_async_busy", 32'(busy_o[0]), 32'd0);
        applyStimulus();
        reset = 1'b0;
    endtask

    initial begin
        int a, d, pick;
        reset         = 1'b1;
        start         = 1'b0;
        num_exp       = '0;
        bus.memwrite  = 1'b0;
        bus.dataaddr  = '0;
        bus.writedata = '0;
        bus.tbl_we    = 1'b0;
        bus.tbl_idx   = '0;
        bus.tbl_addr  = '0;
        bus.tbl_data  = '0;
        modelReset();
        @(negedge clk);
        checkAll();
        reset = 1'b0;

        // Load the table.
        setWrite(0, 8, 3);  applyStimulus();
        setWrite(1, 12, 7); applyStimulus();
        setWrite(2, 20, 1); applyStimulus();
        setWrite(3, 24, 2); applyStimulus();

        // Single-entry pass.
        setStart(1); applyStimulus();
        setStore(8, 3); applyStimulus();
        checkOutput("s1_pass", 32'(pass_o[0]), 32'd1);
        checkOutput("s1_match", 32'(match_o[0]), 32'd1);
        checkOutput("s1_cause", 32'(cause_o[0]), 32'd0);

        // Stray store after one match.
        setStart(2); applyStimulus();
        setStore(8, 3); applyStimulus();
        setStore(16, 5); applyStimulus();
        checkOutput("s2_fail", 32'(fail_o[0]), 32'd1);
        checkOutput("s2_cause", 32'(cause_o[0]), 32'd1);
        checkOutput("s2_match", 32'(match_o[0]), 32'd1);
        checkOutput("s2_ignore_busy", 32'(busy_o[1]), 32'd1);
`ifdef STORE_CHECKER_LOG_EN
        checkOutput("s2_fail_addr", 32'(faddr_o[0]), 32'd16);
        checkOutput("s2_fail_data", 32'(fdata_o[0]), 32'd5);
`endif

        // Retries then pass.
        setStart(1); applyStimulus();
        setStore(8, 9); applyStimulus();
        setStore(8, 9); applyStimulus();
        checkOutput("s3_retry", 32'(retry_o[0]), 32'd2);
        setStore(8, 3); applyStimulus();
        checkOutput("s3_pass", 32'(pass_o[1]), 32'd1);

        // Watchdog: fail on exactly the 16th cycle after arming.
        setStart(1); applyStimulus();
        repeat (TIMEOUT - 1) applyStimulus();
        checkOutput("s4_not_yet", 32'(fail_o[1]), 32'd0);
        applyStimulus();
        checkOutput("s4_timeout", 32'(fail_o[1]), 32'd1);
        checkOutput("s4_cause", 32'(cause_o[1]), 32'd2);

        // Reset mid-run keeps the table.
        setStart(1); applyStimulus();
        applyStimulus();
        resetPulse();
        setStart(1); applyStimulus();
        setStore(8, 3); applyStimulus();
        checkOutput("s5_pass", 32'(pass_o[0]), 32'd1);

        // Start wins over a concurrent store.
        setStart(1); setStore(8, 3); applyStimulus();
        checkOutput("s6_busy", 32'(busy_o[0]), 32'd1);
        checkOutput("s6_match", 32'(match_o[0]), 32'd0);
        setStore(8, 3); applyStimulus();
        checkOutput("s6_pass", 32'(pass_o[0]), 32'd1);

        // Table write together with start from IDLE.
        resetPulse();
        setWrite(0, 40, 4); setStart(1); applyStimulus();
        setStore(40, 4); applyStimulus();
        checkOutput("s7_pass", 32'(pass_o[0]), 32'd1);

        // num_exp above DEPTH is clamped.
        setStart(5); applyStimulus();
        setStore(40, 4); applyStimulus();
        setStore(12, 7); applyStimulus();
        setStore(20, 1); applyStimulus();
        setStore(24, 2); applyStimulus();
        checkOutput("s8_pass", 32'(pass_o[0]), 32'd1);
        checkOutput("s8_match", 32'(match_o[0]), 32'd4);

        // Table writes while armed are dropped.
        setStart(2); applyStimulus();
        setWrite(1, 99, 99); applyStimulus();
        setStore(40, 4); applyStimulus();
        setStore(12, 7); applyStimulus();
        checkOutput("s9_pass", 32'(pass_o[0]), 32'd1);

        // Randomized run.
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 249) == 0) begin
                resetPulse();
            end else begin
                if ($urandom_range(0, 11) == 0) setStart(int'($urandom_range(0, 5)));
                if ($urandom_range(0, 5) == 0)
                    setWrite(int'($urandom_range(0, DEPTH - 1)),
                             4 * int'($urandom_range(1, 6)), int'($urandom_range(0, 3)));
                if ($urandom_range(0, 1) == 1) begin
                    pick = int'($urandom_range(0, 3));
                    if (pick != 0 && m_mode[0] == M_ARMED) begin
                        a = int'(m_taddr[0][m_matched[0]]);
                        d = (pick == 1) ? int'($urandom_range(0, 3))
                                        : int'(m_tdata[0][m_matched[0]]);
                    end else begin
                        a = 4 * int'($urandom_range(1, 6));
                        d = int'($urandom_range(0, 3));
                    end
                    setStore(a, d);
                end
                applyStimulus();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
